// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I MEM-stage data-memory access unit
//
// Issues the load or store held in the EX/MEM register over a req/ready
// data-memory port, stalls the pipeline while the access is outstanding,
// and aligns and extends load data for write-back.
//
// Optional feature: MEM_MISALIGN_TRAP_EN (when defined, misaligned halfword
// and word accesses are not issued and are flagged on misalign).
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   inst                instruction in the MEM stage
//   alu_out             effective byte address (low addrWidth bits used)
//   rs2_rdata           store data
//   hold                external stall; DONE is held while high
//   stall               freeze request to the PC and stage registers
//   dm_req/dm_we        memory request valid / store select
//   dm_addr             word-aligned memory address
//   dm_wstrb/dm_wdata   byte strobes / lane-replicated store data
//   dm_rdata/dm_ready   read word / request completion
//   ld_data/ld_valid    aligned, extended load result / valid in DONE
//   misalign            misaligned-access flag in DONE

module mem_access_unit #(
    parameter int addrWidth = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst,
    input  logic [31:0]          alu_out,
    input  logic [31:0]          rs2_rdata,
    input  logic                 hold,
    output logic                 stall,
    output logic                 dm_req,
    output logic                 dm_we,
    output logic [addrWidth-1:0] dm_addr,
    output logic [3:0]           dm_wstrb,
    output logic [31:0]          dm_wdata,
    input  logic [31:0]          dm_rdata,
    input  logic                 dm_ready,
    output logic [31:0]          ld_data,
    output logic                 ld_valid,
    output logic                 misalign
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state, state_d;

    // Decode
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [1:0] a;
    logic       is_load;
    logic       is_store;
    logic       op_valid;
    logic       mis_now;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign a      = alu_out[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        if (opcode == 7'b0000011) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load = 1'b1;
                default:                                is_load = 1'b0;
            endcase
        end
        if (opcode == 7'b0100011) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: is_store = 1'b1;
                default:                is_store = 1'b0;
            endcase
        end
    end

    assign op_valid = is_load | is_store;

`ifdef MEM_MISALIGN_TRAP_EN
    // funct3[1:0] encodes the access size for every legal load/store.
    assign mis_now = ((funct3[1:0] == 2'b01) && a[0]) ||
                     ((funct3[1:0] == 2'b10) && (a != 2'b00));
`else
    assign mis_now = 1'b0;
`endif

    // Store lane placement
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;

    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = rs2_rdata;
        case (funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << a;
                st_wdata = {4{rs2_rdata[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << {a[1], 1'b0};
                st_wdata = {2{rs2_rdata[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = rs2_rdata;
            end
        endcase
    end

    // Captured op attributes used while the access is in flight
    logic [2:0] ld_f3;
    logic [1:0] ld_off;
    logic       op_load;
    logic       mis_q;

    // Load extraction from the returned word
    logic [31:0] rd_shift;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;

    assign rd_shift = dm_rdata >> {ld_off, 3'b000};
    assign rd_half  = ld_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    always_comb begin
        ld_ext = dm_rdata;
        case (ld_f3)
            3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_ext = {24'h000000, rd_shift[7:0]};
            3'b101:  ld_ext = {16'h0000, rd_half};
            default: ld_ext = dm_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM next-state and combinational outputs
    always_comb begin
        state_d = state;
        stall   = 1'b0;
        dm_req  = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    stall   = 1'b1;
                    state_d = mis_now ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall  = 1'b1;
                dm_req = 1'b1;
                if (dm_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!hold) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request registers, captured once in IDLE so they stay stable for the
    // whole ACCESS phase regardless of what the pipeline presents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_addr  <= '0;
            dm_we    <= 1'b0;
            dm_wstrb <= 4'b0000;
            dm_wdata <= 32'h0;
            ld_f3    <= 3'b000;
            ld_off   <= 2'b00;
            op_load  <= 1'b0;
            mis_q    <= 1'b0;
            ld_data  <= 32'h0;
        end else begin
            if (state == IDLE && op_valid) begin
                op_load <= is_load;
                mis_q   <= mis_now;
                if (!mis_now) begin
                    dm_addr  <= {alu_out[addrWidth-1:2], 2'b00};
                    dm_we    <= is_store;
                    dm_wstrb <= is_store ? st_strb : 4'b0000;
                    dm_wdata <= is_store ? st_wdata : 32'h0;
                    ld_f3    <= funct3;
                    ld_off   <= a;
                end
            end
            if (state == ACCESS && dm_ready && op_load) begin
                ld_data <= ld_ext;
            end
        end
    end

    assign ld_valid = (state == DONE) && op_load && !mis_q;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = (state == DONE) && mis_q;
`else
    assign misalign = 1'b0;
`endif

    // Instruction and address bits this block does not look at
    logic unused_bits;
    assign unused_bits = ^{inst[31:15], inst[11:7], alu_out[31:addrWidth]};

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access unit for the MEM stage of the five-stage RV32I pipeline. It consumes the instruction, effective address and store data held by the EX/MEM stage register, and performs the load or store over a req/ready data-memory port. It generates the `stall` that freezes the stage registers while an access is outstanding. Loaded data is byte-lane aligned and sign- or zero-extended before it is handed to write-back.

## Interface
- `addrWidth`, 15, byte-address width of the data-memory port.

- `clk` in 1: core clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inst` in 32: instruction in MEM stage (from EX/MEM register).
- `alu_out` in 32: effective byte address; bits [addrWidth-1:0] used.
- `rs2_rdata` in 32: store data.
- `hold` in 1: OR of all other stall sources; this block's result is not retired while high.
- `stall` out 1: freeze request to the PC and all stage registers.
- `dm_req` out 1: memory request valid.
- `dm_we` out 1: 1 = store, 0 = load.
- `dm_addr` out addrWidth: word-aligned address, bits [1:0] = 0.
- `dm_wstrb` out 4: byte write strobes (0 for loads).
- `dm_wdata` out 32: lane-replicated store data.
- `dm_rdata` in 32: read word, valid when `dm_ready` is high.
- `dm_ready` in 1: completes the request this cycle.
- `ld_data` out 32: aligned and extended load result, held until the next load completes.
- `ld_valid` out 1: high in DONE for a completed load.
- `misalign` out 1: misaligned-access flag (see Configuration).

## Operation
- Decode: `inst[6:0]` = 0000011 is a load; 0100011 is a store. `inst[14:12]` is funct3.
- Loads use funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores use funct3 000 SB, 001 SH, 010 SW.
- Any other funct3 or opcode is a no-op: no request, no stall, FSM stays IDLE.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE with a valid memory op: register `dm_addr`, `dm_we`, `dm_wstrb` and `dm_wdata`, then go to ACCESS.
  - ACCESS: `dm_req` = 1. On `dm_ready` = 1, capture the load result and go to DONE. Otherwise stay in ACCESS.
  - DONE: stay while `hold` = 1; go to IDLE when `hold` = 0.
- `stall` is combinational: high in IDLE when a valid memory op is decoded, and high in ACCESS. It is low in DONE.
- Handshake:
  - `dm_req` and all `dm_*` outputs are stable from entry into ACCESS until the cycle `dm_ready` is sampled high.
  - `dm_req` drops in the cycle after completion.
  - `dm_ready` outside ACCESS is ignored.
- Store lanes, where a = `alu_out[1:0]`:
  - SB: `dm_wstrb` = 0001<<a, `dm_wdata` = {4{rs2[7:0]}}.
  - SH: `dm_wstrb` = 0011<<{a[1],0}, `dm_wdata` = {2{rs2[15:0]}}.
  - SW: `dm_wstrb` = 1111, `dm_wdata` = rs2.
- Load extraction:
  - Byte loads select byte a of `dm_rdata`. Halfword loads select halfword a[1]. LW takes the whole word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Reset: state IDLE. `dm_req`, `dm_we`, `dm_wstrb`, `dm_wdata`, `dm_addr`, `ld_data`, `ld_valid` and `misalign` are all 0. `stall` is 0 unless a valid op is presented.
- Reset during ACCESS drops `dm_req` immediately and abandons the request; the memory must tolerate this.

## Timing
- Minimum access: `stall` high for 2 cycles (decode cycle, then ACCESS with `dm_ready` = 1). DONE follows with `stall` low.
- Every ACCESS cycle with `dm_ready` = 0 adds one stall cycle.
- `ld_data` updates on the edge that leaves ACCESS. `ld_valid` is high for every DONE cycle of a load.
- Because DONE always has `stall` low, the next instruction enters MEM at the end of the first DONE cycle with `hold` = 0. Back-to-back memory ops are therefore spaced by at least one DONE cycle.
- An op is never re-issued while DONE is held by `hold`.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A halfword access with a[0] = 1, or a word access with a ≠ 0, is not issued.
  - The FSM goes IDLE→DONE, with `stall` high for 1 cycle.
  - In DONE, `misalign` = 1, `ld_valid` = 0, and `ld_data` is unchanged.
- Not defined:
  - `misalign` is tied to 0.
  - Halfword accesses ignore a[0]; word accesses ignore a[1:0]. The access proceeds normally.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF with `dm_ready` on the first ACCESS cycle:
  - `dm_addr` = 0x100, `stall` high for 2 cycles.
  - DONE shows `ld_data` = 0xDEADBEEF and `ld_valid` = 1.
- SB at 0x103 with rs2 = 0x000000A5:
  - `dm_we` = 1, `dm_wstrb` = 1000, `dm_wdata` = 0xA5A5A5A5, `dm_addr` = 0x100.
- LB / LBU at 0x102 with `dm_rdata` = 0x00800000:
  - LB gives `ld_data` = 0xFFFFFF80; LBU gives 0x00000080.
- LH at 0x202 with `dm_ready` delayed 3 cycles, `dm_rdata` = 0x8001xxxx:
  - `dm_*` outputs stable throughout; `stall` high for 5 cycles.
  - `ld_data` = 0xFFFF8001.
- `hold` = 1 for 2 cycles in DONE after SW:
  - Exactly one `dm_req` handshake occurs; the FSM leaves DONE only after `hold` falls.
- `rst` pulsed mid-ACCESS:
  - `dm_req` is 0 in the same cycle and all outputs are 0.
- With `MEM_MISALIGN_TRAP_EN` defined, LW at 0x101:
  - No `dm_req`, `misalign` = 1 for one cycle, `stall` high for 1 cycle.
